// File: rtl/pc_fetch_unit.sv
// Program-counter and fetch-control stage.
// Holds the registered PC that addresses instruction memory, selects the next PC from
// sequential / redirect / stall, detects the halt word and keeps sticky halt and
// misalignment status plus a retired-instruction counter.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] HALT_INSN    = 32'h0000_0063
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] retired_count
);

    logic is_halt_word;
    logic target_misaligned;

    // Decode the current fetch and redirect request; sequential PC wraps naturally mod 2^32.
    always_comb begin
        pc_plus4          = pc + 32'd4;
        fetch_valid       = !halted;
        is_halt_word      = (instruction == HALT_INSN);
        target_misaligned = (redirect_target[1:0] != 2'b00);
    end

    // PC / status / counter update; priority: reset, halted, stall, halt word, redirect, step.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_VECTOR;
            halted        <= 1'b0;
            misalign_err  <= 1'b0;
            retired_count <= 32'd0;
        end else if (!halted && !stall) begin
            if (is_halt_word) begin
                // Halt word beats a simultaneous redirect and is not counted as retired.
                halted <= 1'b1;
            end else if (redirect_valid) begin
                if (target_misaligned) begin
                    // Never load an unaligned PC; stop fetching instead.
                    misalign_err <= 1'b1;
                    halted       <= 1'b1;
                end else begin
                    pc            <= redirect_target;
                    retired_count <= retired_count + 32'd1;
                end
            end else begin
                pc            <= pc_plus4;
                retired_count <= retired_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instruction;

    logic [31:0] pc, pc_plus4, retired_count;
    logic        fetch_valid, halted, misalign_err;

    logic [31:0] pc_b, pc_plus4_b, retired_count_b;
    logic        fetch_valid_b, halted_b, misalign_err_b;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'h0000_0063;

    pc_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instruction     (instruction),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .fetch_valid     (fetch_valid),
        .halted          (halted),
        .misalign_err    (misalign_err),
        .retired_count   (retired_count)
    );

    pc_fetch_unit #(
        .RESET_VECTOR (32'h0000_1000)
    ) dut_rv (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instruction     (instruction),
        .pc              (pc_b),
        .pc_plus4        (pc_plus4_b),
        .fetch_valid     (fetch_valid_b),
        .halted          (halted_b),
        .misalign_err    (misalign_err_b),
        .retired_count   (retired_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; inputs are changed only after this returns.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        instruction     = NOP;
        step();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_pc", pc, 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h4);
        check("rst_cnt", retired_count, 32'h0);
        check("rst_halted", {31'd0, halted}, 32'h0);
        check("rst_mis", {31'd0, misalign_err}, 32'h0);
        check("rst_fv", {31'd0, fetch_valid}, 32'h1);
        check("rv_pc", pc_b, 32'h0000_1000);
        check("rv_pc_plus4", pc_plus4_b, 32'h0000_1004);

        // Sequential fetch: 4,8,C,10.
        for (int i = 1; i <= 4; i++) begin
            step();
            check("seq_pc", pc, 32'(4 * i));
            check("seq_cnt", retired_count, 32'(i));
        end

        // Redirect at pc=8, first held off by stall.
        do_reset();
        step();
        step();
        check("pre_redir_pc", pc, 32'h8);
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        stall           = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc, 32'h8);
            check("stall_cnt", retired_count, 32'h2);
        end
        stall = 1'b0;
        step();
        check("redir_pc", pc, 32'h40);
        check("redir_cnt", retired_count, 32'h3);
        redirect_valid = 1'b0;
        step();
        check("post_redir_pc", pc, 32'h44);
        check("post_redir_cnt", retired_count, 32'h4);

        // Halt word at pc=C, then redirects ignored for 10 cycles.
        do_reset();
        step();
        step();
        step();
        check("pre_halt_pc", pc, 32'hC);
        instruction = HALT;
        step();
        check("halt_flag", {31'd0, halted}, 32'h1);
        check("halt_fv", {31'd0, fetch_valid}, 32'h0);
        check("halt_pc", pc, 32'hC);
        check("halt_cnt", retired_count, 32'h3);
        instruction     = NOP;
        redirect_valid  = 1'b1;
        redirect_target = 32'h80;
        for (int i = 0; i < 10; i++) begin
            step();
            check("halted_pc", pc, 32'hC);
            check("halted_cnt", retired_count, 32'h3);
        end
        check("halted_mis", {31'd0, misalign_err}, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_from_halt_pc", pc, 32'h0);
        check("rst_from_halt_flag", {31'd0, halted}, 32'h0);

        // Halt word beats a simultaneous redirect.
        do_reset();
        step();
        instruction     = HALT;
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        step();
        check("halt_vs_redir_pc", pc, 32'h4);
        check("halt_vs_redir_cnt", retired_count, 32'h1);
        check("halt_vs_redir_flag", {31'd0, halted}, 32'h1);

        // Misaligned redirect target.
        do_reset();
        redirect_valid  = 1'b1;
        redirect_target = 32'h42;
        step();
        check("mis_flag", {31'd0, misalign_err}, 32'h1);
        check("mis_halted", {31'd0, halted}, 32'h1);
        check("mis_pc", pc, 32'h0);
        check("mis_cnt", retired_count, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mis_clr_flag", {31'd0, misalign_err}, 32'h0);
        check("mis_clr_halted", {31'd0, halted}, 32'h0);
        check("mis_clr_pc", pc, 32'h0);

        // PC wraparound.
        do_reset();
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        check("wrap_top_pc", pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", pc_plus4, 32'h0);
        redirect_valid = 1'b0;
        step();
        check("wrap_pc", pc, 32'h0);
        check("wrap_cnt", retired_count, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
